biu_bus_master: RTL and testbench

- Request sequencer that sits directly upstream of the BIU peripheral memory model.
- Accepts single or burst read/write requests from a CPU-side request/stream interface.
- Drives the bus side: lock/strobe, address, byte selects, CTI on prot, BTE on type, write data.
- Counts acks, returns read data, and terminates on bus error or timeout.

---
 rtl/biu_bus_master.sv | 117 +++++++++++
 tb/tb_biu_bus_master.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/biu_bus_master.sv
// biu_bus_master: sequences single/burst CPU requests onto the BIU bus with ack counting, error and timeout abort
module biu_bus_master #(
  parameter int TIMEOUT   = 64,
  parameter int MAX_BEATS = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [31:0] req_addr_i,
  input  logic        req_we_i,
  input  logic [3:0]  req_be_i,
  input  logic [3:0]  req_len_i,
  input  logic [1:0]  req_bte_i,
  input  logic [31:0] wdata_i,
  input  logic        wdata_valid_i,
  output logic        wdata_ready_o,
  output logic [31:0] rdata_o,
  output logic        rdata_valid_o,
  output logic        done_o,
  output logic        done_err_o,
  output logic        lock_o,
  output logic        stb_o,
  output logic [31:0] adr_o,
  output logic [3:0]  size_o,
  output logic [1:0]  type_o,
  output logic [2:0]  prot_o,
  output logic        we_o,
  output logic [31:0] d_o,
  input  logic [31:0] q_i,
  input  logic        ack_i,
  input  logic        err_i
);
  typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;
  state_t state;
  logic [$clog2(MAX_BEATS)-1:0] len_r, rem;
  logic [9:0] tcnt;
  logic [29:0] a, m, a_nxt;
  logic beat, abort, last, unused_addr;
  assign unused_addr = ^req_addr_i[1:0];
  // Bus strobe is gated by write-data availability; beat/abort qualifiers derive from it
  always_comb begin
    stb_o = state == ACTIVE && (!we_o || wdata_valid_i);
    beat = stb_o && ack_i && !err_i;
    abort = stb_o && (err_i || (!ack_i && tcnt == 10'(TIMEOUT - 1)));
    last = rem == '0;
    prot_o = (state != ACTIVE || len_r == '0) ? 3'b000 : last ? 3'b111 : 3'b010;
    wdata_ready_o = beat && we_o;
    d_o = (state == ACTIVE && we_o) ? wdata_i : '0;
    a = adr_o[31:2];
    m = type_o == 2'd1 ? 30'd3 : type_o == 2'd2 ? 30'd7 : 30'd15;
    a_nxt = type_o == 2'd0 ? a + 30'd1 : (a & ~m) | ((a + 30'd1) & m);
  end
  // Transfer sequencer: accept, beat counting, address advance, completion/abort
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      req_ready_o <= 1'b0;
      lock_o <= 1'b0;
      adr_o <= '0;
      size_o <= '0;
      type_o <= '0;
      we_o <= 1'b0;
      len_r <= '0;
      rem <= '0;
      tcnt <= '0;
      rdata_o <= '0;
      rdata_valid_o <= 1'b0;
      done_o <= 1'b0;
      done_err_o <= 1'b0;
    end else begin
      rdata_valid_o <= beat && !we_o;
      if (beat && !we_o) rdata_o <= q_i;
      done_o <= 1'b0;
      done_err_o <= 1'b0;
      case (state)
        IDLE: begin
          tcnt <= '0;
          req_ready_o <= 1'b1;
          if (req_valid_i && req_ready_o) begin
            req_ready_o <= 1'b0;
            state <= ACTIVE;
            lock_o <= 1'b1;
            adr_o <= {req_addr_i[31:2], 2'b00};
            size_o <= req_be_i;
            type_o <= req_bte_i;
            we_o <= req_we_i;
            len_r <= req_len_i;
            rem <= req_len_i;
          end
        end
        ACTIVE: begin
          tcnt <= (stb_o && ack_i) ? '0 : stb_o ? tcnt + 10'd1 : tcnt;
          if (abort) begin
            state <= DONE;
            lock_o <= 1'b0;
            done_o <= 1'b1;
            done_err_o <= 1'b1;
          end else if (beat && last) begin
            state <= DONE;
            lock_o <= 1'b0;
            done_o <= 1'b1;
          end else if (beat) begin
            rem <= rem - 1'b1;
            adr_o <= {a_nxt, 2'b00};
          end
        end
        DONE: begin
          state <= IDLE;
          tcnt <= '0;
          req_ready_o <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_biu_bus_master.sv
// tb_biu_bus_master: directed checks of the bus master against a simple word memory slave
module tb_biu_bus_master;
  logic clk = 1'b0, rst = 1'b1;
  logic req_valid_i = 1'b0, req_we_i = 1'b0, wdata_valid_i = 1'b0, err_i = 1'b0;
  logic [31:0] req_addr_i = '0, wdata_i = '0;
  logic [3:0] req_be_i = '0, req_len_i = '0;
  logic [1:0] req_bte_i = '0;
  logic req_ready_o, wdata_ready_o, rdata_valid_o, done_o, done_err_o, lock_o, stb_o, we_o, ack_i;
  logic [31:0] rdata_o, adr_o, d_o, q_i;
  logic [3:0] size_o;
  logic [1:0] type_o;
  logic [2:0] prot_o;
  logic ack_auto = 1'b0, ack_man = 1'b0;
  logic [31:0] mem [0:1023];
  int passed = 0, total = 0;

  biu_bus_master #(.TIMEOUT(64), .MAX_BEATS(16)) dut (
    .clk(clk), .rst(rst), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_addr_i(req_addr_i), .req_we_i(req_we_i), .req_be_i(req_be_i), .req_len_i(req_len_i),
    .req_bte_i(req_bte_i), .wdata_i(wdata_i), .wdata_valid_i(wdata_valid_i),
    .wdata_ready_o(wdata_ready_o), .rdata_o(rdata_o), .rdata_valid_o(rdata_valid_o),
    .done_o(done_o), .done_err_o(done_err_o), .lock_o(lock_o), .stb_o(stb_o), .adr_o(adr_o),
    .size_o(size_o), .type_o(type_o), .prot_o(prot_o), .we_o(we_o), .d_o(d_o), .q_i(q_i),
    .ack_i(ack_i), .err_i(err_i));

  always #5 clk = ~clk;
  assign ack_i = ack_auto ? stb_o : ack_man;
  assign q_i = mem[adr_o[11:2]];

  initial for (int i = 0; i < 1024; i++) mem[i] = 32'hA000_0000 + i;

  // Memory slave: byte-enabled write on an acknowledged write beat
  always @(posedge clk)
    if (stb_o && ack_i && !err_i && we_o)
      for (int b = 0; b < 4; b++) if (size_o[b]) mem[adr_o[11:2]][8*b +: 8] <= d_o[8*b +: 8];

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic issue(input logic [31:0] addr, input logic we, input logic [3:0] be,
                       input logic [3:0] len, input logic [1:0] bte);
    int k = 0;
    while (!req_ready_o && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    total++;
    if (req_ready_o !== 1'b1) $display("FAIL issue_ready got %b exp 1", req_ready_o); else passed++;
    req_valid_i = 1'b1; req_addr_i = addr; req_we_i = we; req_be_i = be; req_len_i = len; req_bte_i = bte;
    @(posedge clk); #1;
    req_valid_i = 1'b0;
  endtask

  task automatic test_reset;
    #1;
    total++; if (lock_o !== 1'b0) $display("FAIL rst_lock got %b exp 0", lock_o); else passed++;
    total++; if (stb_o !== 1'b0) $display("FAIL rst_stb got %b exp 0", stb_o); else passed++;
    total++; if (req_ready_o !== 1'b0) $display("FAIL rst_ready got %b exp 0", req_ready_o); else passed++;
    total++; if (done_o !== 1'b0) $display("FAIL rst_done got %b exp 0", done_o); else passed++;
    total++; if (adr_o !== 32'h0) $display("FAIL rst_adr got %h exp 0", adr_o); else passed++;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    total++; if (req_ready_o !== 1'b1) $display("FAIL post_rst_ready got %b exp 1", req_ready_o); else passed++;
  endtask

  task automatic test_single_read;
    issue(32'h10, 1'b0, 4'hF, 4'd0, 2'd0);
    total++; if (lock_o !== 1'b1) $display("FAIL sr_lock got %b exp 1", lock_o); else passed++;
    total++; if (stb_o !== 1'b1) $display("FAIL sr_stb got %b exp 1", stb_o); else passed++;
    total++; if (prot_o !== 3'b000) $display("FAIL sr_prot got %b exp 000", prot_o); else passed++;
    total++; if (adr_o !== 32'h10) $display("FAIL sr_adr got %h exp 10", adr_o); else passed++;
    total++; if (req_ready_o !== 1'b0) $display("FAIL sr_ready got %b exp 0", req_ready_o); else passed++;
    @(posedge clk); #1;
    ack_man = 1'b1;
    @(posedge clk); #1;
    ack_man = 1'b0;
    total++; if (rdata_valid_o !== 1'b1) $display("FAIL sr_rvalid got %b exp 1", rdata_valid_o); else passed++;
    total++; if (rdata_o !== 32'hA000_0004) $display("FAIL sr_rdata got %h exp a0000004", rdata_o); else passed++;
    total++; if (done_o !== 1'b1) $display("FAIL sr_done got %b exp 1", done_o); else passed++;
    total++; if (done_err_o !== 1'b0) $display("FAIL sr_done_err got %b exp 0", done_err_o); else passed++;
    total++; if (lock_o !== 1'b0) $display("FAIL sr_lock_off got %b exp 0", lock_o); else passed++;
    @(posedge clk); #1;
    total++; if (done_o !== 1'b0) $display("FAIL sr_done_pulse got %b exp 0", done_o); else passed++;
    total++; if (req_ready_o !== 1'b1) $display("FAIL sr_ready_back got %b exp 1", req_ready_o); else passed++;
  endtask

  task automatic test_burst_read;
    logic [31:0] ea [4] = '{32'h20, 32'h24, 32'h28, 32'h2C};
    logic [2:0] ep [4] = '{3'b010, 3'b010, 3'b010, 3'b111};
    int n = 0;
    ack_auto = 1'b1;
    issue(32'h20, 1'b0, 4'hF, 4'd3, 2'd0);
    for (int i = 0; i < 4; i++) begin
      total++; if (adr_o !== ea[i]) $display("FAIL br_adr%0d got %h exp %h", i, adr_o, ea[i]); else passed++;
      total++; if (prot_o !== ep[i]) $display("FAIL br_prot%0d got %b exp %b", i, prot_o, ep[i]); else passed++;
      @(posedge clk); #1;
      if (rdata_valid_o) n++;
    end
    ack_auto = 1'b0;
    total++; if (n !== 4) $display("FAIL br_rvalid_count got %0d exp 4", n); else passed++;
    total++; if (rdata_o !== 32'hA000_000B) $display("FAIL br_last_rdata got %h exp a000000b", rdata_o); else passed++;
    total++; if (lock_o !== 1'b0) $display("FAIL br_lock_off got %b exp 0", lock_o); else passed++;
    total++; if (done_o !== 1'b1) $display("FAIL br_done got %b exp 1", done_o); else passed++;
    @(posedge clk); #1;
    total++; if (rdata_valid_o !== 1'b0) $display("FAIL br_extra_rvalid got %b exp 0", rdata_valid_o); else passed++;
  endtask

  task automatic test_wrap4;
    logic [31:0] ea [4] = '{32'h38, 32'h3C, 32'h30, 32'h34};
    ack_auto = 1'b1;
    issue(32'h3B, 1'b0, 4'hF, 4'd3, 2'd1);
    for (int i = 0; i < 4; i++) begin
      total++; if (adr_o !== ea[i]) $display("FAIL w4_adr%0d got %h exp %h", i, adr_o, ea[i]); else passed++;
      total++; if (type_o !== 2'b01) $display("FAIL w4_type%0d got %b exp 01", i, type_o); else passed++;
      @(posedge clk); #1;
    end
    ack_auto = 1'b0;
    total++; if (rdata_o !== 32'hA000_000D) $display("FAIL w4_last_rdata got %h exp a000000d", rdata_o); else passed++;
    total++; if (done_o !== 1'b1) $display("FAIL w4_done got %b exp 1", done_o); else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_write_gap;
    int nw = 0;
    ack_auto = 1'b1;
    issue(32'h40, 1'b1, 4'hF, 4'd1, 2'd0);
    wdata_valid_i = 1'b1; wdata_i = 32'h1111_2222;
    #1;
    total++; if (stb_o !== 1'b1) $display("FAIL wr_stb0 got %b exp 1", stb_o); else passed++;
    total++; if (prot_o !== 3'b010) $display("FAIL wr_prot0 got %b exp 010", prot_o); else passed++;
    if (wdata_ready_o) nw++;
    @(posedge clk); #1;
    wdata_valid_i = 1'b0; err_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      total++; if (stb_o !== 1'b0) $display("FAIL wr_gap_stb%0d got %b exp 0", k, stb_o); else passed++;
      total++; if (lock_o !== 1'b1) $display("FAIL wr_gap_lock%0d got %b exp 1", k, lock_o); else passed++;
      total++; if (adr_o !== 32'h44) $display("FAIL wr_gap_adr%0d got %h exp 44", k, adr_o); else passed++;
      if (wdata_ready_o) nw++;
      @(posedge clk); #1;
    end
    err_i = 1'b0;
    wdata_valid_i = 1'b1; wdata_i = 32'h3333_4444;
    #1;
    total++; if (prot_o !== 3'b111) $display("FAIL wr_prot1 got %b exp 111", prot_o); else passed++;
    if (wdata_ready_o) nw++;
    @(posedge clk); #1;
    wdata_valid_i = 1'b0;
    total++; if (nw !== 2) $display("FAIL wr_ready_count got %0d exp 2", nw); else passed++;
    total++; if (done_o !== 1'b1 || done_err_o !== 1'b0) $display("FAIL wr_done got %b%b exp 10", done_o, done_err_o); else passed++;
    total++; if (lock_o !== 1'b0) $display("FAIL wr_lock_off got %b exp 0", lock_o); else passed++;
    @(posedge clk); #1;
    issue(32'h40, 1'b0, 4'hF, 4'd1, 2'd0);
    @(posedge clk); #1;
    total++; if (rdata_valid_o !== 1'b1 || rdata_o !== 32'h1111_2222) $display("FAIL rb0 got %b/%h exp 1/11112222", rdata_valid_o, rdata_o); else passed++;
    @(posedge clk); #1;
    total++; if (rdata_valid_o !== 1'b1 || rdata_o !== 32'h3333_4444) $display("FAIL rb1 got %b/%h exp 1/33334444", rdata_valid_o, rdata_o); else passed++;
    ack_auto = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_error;
    ack_auto = 1'b1;
    issue(32'h400, 1'b0, 4'hF, 4'd0, 2'd0);
    err_i = 1'b1;
    #1;
    total++; if (stb_o !== 1'b1) $display("FAIL err_stb got %b exp 1", stb_o); else passed++;
    @(posedge clk); #1;
    err_i = 1'b0; ack_auto = 1'b0;
    total++; if (rdata_valid_o !== 1'b0) $display("FAIL err_rvalid got %b exp 0", rdata_valid_o); else passed++;
    total++; if (done_o !== 1'b1 || done_err_o !== 1'b1) $display("FAIL err_done got %b%b exp 11", done_o, done_err_o); else passed++;
    total++; if (lock_o !== 1'b0) $display("FAIL err_lock got %b exp 0", lock_o); else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_timeout;
    int n = 0;
    logic seen = 1'b0;
    issue(32'h0, 1'b0, 4'hF, 4'd0, 2'd0);
    for (int k = 0; k < 200; k++) begin
      if (done_o) begin
        seen = 1'b1;
        break;
      end
      if (stb_o) n++;
      @(posedge clk); #1;
    end
    total++; if (seen !== 1'b1) $display("FAIL to_done_seen got %b exp 1", seen); else passed++;
    total++; if (n !== 64) $display("FAIL to_stb_cycles got %0d exp 64", n); else passed++;
    total++; if (done_err_o !== 1'b1) $display("FAIL to_done_err got %b exp 1", done_err_o); else passed++;
    total++; if (lock_o !== 1'b0) $display("FAIL to_lock got %b exp 0", lock_o); else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid;
    ack_auto = 1'b1;
    issue(32'h80, 1'b0, 4'hF, 4'd7, 2'd0);
    @(posedge clk); #1;
    #2 rst = 1'b1;
    #1;
    total++; if (lock_o !== 1'b0 || stb_o !== 1'b0) $display("FAIL rm_bus got %b%b exp 00", lock_o, stb_o); else passed++;
    total++; if (adr_o !== 32'h0 || prot_o !== 3'b000) $display("FAIL rm_adr got %h/%b exp 0/000", adr_o, prot_o); else passed++;
    total++; if (rdata_valid_o !== 1'b0 || done_o !== 1'b0) $display("FAIL rm_flags got %b%b exp 00", rdata_valid_o, done_o); else passed++;
    @(posedge clk); #1;
    rst = 1'b0; ack_auto = 1'b0;
    @(posedge clk); #1;
    total++; if (done_o !== 1'b0) $display("FAIL rm_no_done got %b exp 0", done_o); else passed++;
    total++; if (req_ready_o !== 1'b1) $display("FAIL rm_ready got %b exp 1", req_ready_o); else passed++;
  endtask

  initial begin
    test_reset;
    test_single_read;
    test_burst_read;
    test_wrap4;
    test_write_gap;
    test_error;
    test_timeout;
    test_reset_mid;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
